// File: rtl/apb_regfile_slave.sv
// -----------------------------------------------------------------------------
// apb_regfile_slave
//
// APB slave holding a bank of NUM_REGS word-wide registers. Writes honour byte
// strobes, every access phase is stretched by WAIT_STATES PREADY-low cycles,
// and accesses to unmapped/misaligned addresses or writes to read-only
// registers complete with PSLVERR. Read-only registers (RO_MASK) return and
// expose the matching slice of ro_i instead of stored state.
//
// Ports
//   clk      in   clock, everything on the rising edge
//   rst      in   synchronous reset, active-high
//   PADDR    in   APB byte address
//   PWRITE   in   1 = write, 0 = read
//   PSEL     in   slave select
//   PENABLE  in   access phase qualifier
//   PWDATA   in   write data
//   PSTRB    in   byte write strobes
//   PRDATA   out  read data, non-zero only in the completion cycle of a good read
//   PREADY   out  transfer complete
//   PSLVERR  out  transfer error, only in the completion cycle
//   regs_o   out  register view, reg i at [i*DATA_W +: DATA_W]
//   ro_i     in   status words returned for read-only registers
// -----------------------------------------------------------------------------
module apb_regfile_slave #(
    parameter int unsigned        ADDR_W      = 32,
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter int unsigned        WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
    parameter logic [DATA_W-1:0]  RESET_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic                         PWRITE,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic [DATA_W-1:0]            PWDATA,
    input  logic [DATA_W/8-1:0]          PSTRB,
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_i
);

    localparam int unsigned NumBytes  = DATA_W / 8;
    localparam int unsigned ByteShift = (NumBytes > 1) ? $clog2(NumBytes) : 0;
    localparam int unsigned IdxW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // Size of the mapped window in bytes and the mask of sub-word address bits.
    localparam logic [ADDR_W-1:0] Span      = ADDR_W'(NUM_REGS * NumBytes);
    localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'(NumBytes - 1);

    // Counter is 4 bits wide; WAIT_STATES is limited to 0..15.
    localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e                             state_q, state_d;
    logic [3:0]                         cnt_q, cnt_d;
    logic [IdxW-1:0]                    idx_q, idx_d;
    logic                               valid_q, valid_d;
    logic                               ro_q, ro_d;
    logic                               write_q, write_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;

    // Status inputs viewed as an array of words.
    logic [NUM_REGS-1:0][DATA_W-1:0]    ro_w;
    assign ro_w = ro_i;

    // ------------------------------------------------------------------------
    // Address decode (used only at setup; result latched for the access phase)
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] dec_off;
    logic              dec_valid;
    logic [IdxW-1:0]   dec_idx;
    logic              dec_ro;

    always_comb begin
        dec_off   = PADDR - BASE_ADDR;
        // The >= check rejects addresses below the base, whose offset wraps.
        dec_valid = (PADDR >= BASE_ADDR) && (dec_off < Span) &&
                    ((dec_off & AlignMask) == '0);
        dec_idx   = IdxW'(dec_off >> ByteShift);
        dec_ro    = dec_valid && RO_MASK[dec_idx];
    end

    // ------------------------------------------------------------------------
    // Transfer qualifiers
    // ------------------------------------------------------------------------
    logic pready_w;
    logic complete;
    logic err;
    logic commit;
    logic rd_hit;

    always_comb begin
        pready_w = (state_q == StAccess) && (cnt_q == 4'd0);
        complete = pready_w && PSEL && PENABLE;
        err      = complete && (!valid_q || (write_q && ro_q));
        commit   = complete && write_q && valid_q && !ro_q;
        rd_hit   = complete && !write_q && valid_q;
    end

    // ------------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ro_d    = ro_q;
        write_d = write_q;

        unique case (state_q)
            StIdle: begin
                if (PSEL && !PENABLE) begin
                    state_d = StAccess;
                    cnt_d   = WaitLoad;
                    idx_d   = dec_idx;
                    valid_d = dec_valid;
                    ro_d    = dec_ro;
                    write_d = PWRITE;
                end
            end
            StAccess: begin
                if (!PSEL) begin
                    // Master abandoned the transfer: nothing is committed.
                    state_d = StIdle;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (PENABLE) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Register bank next state: byte-strobed write on commit only
    // ------------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            for (int b = 0; b < int'(NumBytes); b++) begin
                if (PSTRB[b]) begin
                    regs_d[idx_q][b*8 +: 8] = PWDATA[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ro_q    <= 1'b0;
            write_q <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ro_q    <= ro_d;
            write_q <= write_d;
            regs_q  <= regs_d;
        end
    end

    // ------------------------------------------------------------------------
    // APB outputs
    // ------------------------------------------------------------------------
    always_comb begin
        PREADY  = pready_w;
        PSLVERR = err;
        PRDATA  = '0;
        if (rd_hit) begin
            PRDATA = ro_q ? ro_w[idx_q] : regs_q[idx_q];
        end
    end

    // ------------------------------------------------------------------------
    // Register view: RO slots show live status, RW slots show stored state
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_view
        if (RO_MASK[i]) begin : g_ro
            assign regs_o[i*DATA_W +: DATA_W] = ro_w[i];
        end else begin : g_rw
            assign regs_o[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

endmodule
